axi_lite_reg_sequencer: RTL

Fully decoupled AXI-Lite slave to RegBus sequencer for peripheral register access.
- Accepts AW, W and AR beats independently, in any order and in any cycle.
- Arbitrates round-robin between pending writes and reads and drives one RegBus transaction at a time, held until the target completes it.
- Returns B/R responses from holding registers so master back-pressure never stalls the RegBus.

---
 rtl/axi_lite_reg_sequencer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_reg_sequencer.sv
// AXI-Lite slave to RegBus sequencer.
// Accepts AW, W and AR beats independently into 1-entry buffers. Pending
// writes and reads are arbitrated round-robin, and one RegBus access at a
// time is driven until the target acknowledges it. B and R responses are
// returned from holding registers, so master back-pressure never stalls
// the RegBus.
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   axi_lite_req_i AXI-Lite request channels (aw, w, ar, b_ready, r_ready)
//   axi_lite_rsp_o AXI-Lite response channels (readies, b, r)
//   reg_req_o      RegBus request (addr, write, wdata, wstrb, valid)
//   reg_rsp_i      RegBus response (rdata, error, ready)

package axi_lite_reg_sequencer_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
  } axi_lite_ax_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
  } axi_lite_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_lite_b_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_lite_r_t r;
    logic        r_valid;
  } axi_lite_rsp_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
    logic                 valid;
  } reg_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } reg_rsp_t;

endpackage

module axi_lite_reg_sequencer #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter type axi_lite_req_t = axi_lite_reg_sequencer_pkg::axi_lite_req_t,
  parameter type axi_lite_rsp_t = axi_lite_reg_sequencer_pkg::axi_lite_rsp_t,
  parameter type reg_req_t      = axi_lite_reg_sequencer_pkg::reg_req_t,
  parameter type reg_rsp_t      = axi_lite_reg_sequencer_pkg::reg_rsp_t
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  axi_lite_req_t axi_lite_req_i,
  output axi_lite_rsp_t axi_lite_rsp_o,
  output reg_req_t      reg_req_o,
  input  reg_rsp_t      reg_rsp_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;
  typedef enum logic {PrioWr, PrioRd} prio_e;

  state_e state_q, state_d;
  prio_e  prio_q, prio_d;

  logic                 aw_full_q, w_full_q, ar_full_q, b_full_q, r_full_q;
  logic [AddrWidth-1:0] aw_addr_q, ar_addr_q;
  logic [DataWidth-1:0] w_data_q, r_data_q;
  logic [StrbWidth-1:0] w_strb_q;
  logic [1:0]           b_resp_q, r_resp_q;

  logic aw_hs, w_hs, ar_hs;
  logic wr_elig, rd_elig, wr_done, rd_done;

  // Beats accepted this cycle count as buffered for arbitration, so a
  // request can start the cycle after its last beat is accepted.
  assign aw_hs   = axi_lite_req_i.aw_valid & ~aw_full_q;
  assign w_hs    = axi_lite_req_i.w_valid  & ~w_full_q;
  assign ar_hs   = axi_lite_req_i.ar_valid & ~ar_full_q;
  assign wr_elig = (aw_full_q | aw_hs) & (w_full_q | w_hs) & ~b_full_q;
  assign rd_elig = (ar_full_q | ar_hs) & ~r_full_q;
  assign wr_done = (state_q == StWrite) & reg_rsp_i.ready;
  assign rd_done = (state_q == StRead)  & reg_rsp_i.ready;

  // State and arbitration-priority registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      prio_q  <= PrioWr;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Next state, priority update and RegBus request drive.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    reg_req_o = '0;
    case (state_q)
      StIdle: begin
        if (wr_elig && (!rd_elig || prio_q == PrioWr)) begin
          state_d = StWrite;
        end else if (rd_elig) begin
          state_d = StRead;
        end
        if (wr_elig && rd_elig) begin
          prio_d = (prio_q == PrioWr) ? PrioRd : PrioWr;
        end
      end
      StWrite: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.write = 1'b1;
        reg_req_o.addr  = aw_addr_q;
        reg_req_o.wdata = w_data_q;
        reg_req_o.wstrb = w_strb_q;
        if (reg_rsp_i.ready) state_d = StIdle;
      end
      StRead: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.addr  = ar_addr_q;
        if (reg_rsp_i.ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Input buffers: fill on handshake, drain when their access completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= axi_lite_req_i.aw.addr;
      end else if (wr_done) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= axi_lite_req_i.w.data;
        w_strb_q <= axi_lite_req_i.w.strb;
      end else if (wr_done) begin
        w_full_q <= 1'b0;
      end
      if (ar_hs) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= axi_lite_req_i.ar.addr;
      end else if (rd_done) begin
        ar_full_q <= 1'b0;
      end
    end
  end

  // Response holding registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_full_q <= 1'b0;
      b_resp_q <= RespOkay;
      r_full_q <= 1'b0;
      r_resp_q <= RespOkay;
      r_data_q <= '0;
    end else begin
      if (wr_done) begin
        b_full_q <= 1'b1;
        b_resp_q <= reg_rsp_i.error ? RespSlvErr : RespOkay;
      end else if (b_full_q && axi_lite_req_i.b_ready) begin
        b_full_q <= 1'b0;
      end
      if (rd_done) begin
        r_full_q <= 1'b1;
        r_data_q <= reg_rsp_i.rdata;
        r_resp_q <= reg_rsp_i.error ? RespSlvErr : RespOkay;
      end else if (r_full_q && axi_lite_req_i.r_ready) begin
        r_full_q <= 1'b0;
      end
    end
  end

  // AXI-Lite response channels straight from buffer and holding state.
  always_comb begin
    axi_lite_rsp_o          = '0;
    axi_lite_rsp_o.aw_ready = ~aw_full_q;
    axi_lite_rsp_o.w_ready  = ~w_full_q;
    axi_lite_rsp_o.ar_ready = ~ar_full_q;
    axi_lite_rsp_o.b_valid  = b_full_q;
    axi_lite_rsp_o.b.resp   = b_resp_q;
    axi_lite_rsp_o.r_valid  = r_full_q;
    axi_lite_rsp_o.r.data   = r_data_q;
    axi_lite_rsp_o.r.resp   = r_resp_q;
  end

endmodule
